// File: rtl/seq_detect_param.sv
// seq_detect_param: serial dual-pattern detector.
// Shifts the serial input D into a history window (newest bit in the LSB) and
// raises the registered one-cycle flags F0/F1 when the window equals PAT0/PAT1.
// Each flag has a saturating hit counter. Overlapped or non-overlapped detection
// is selected at run time by ovl.
module seq_detect_param #(
    parameter int                PAT_W = 4,
    parameter logic [PAT_W-1:0]  PAT0  = 4'b1101,
    parameter logic [PAT_W-1:0]  PAT1  = 4'b0110,
    parameter int                CNT_W = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             D,
    input  logic             en,
    input  logic             ovl,
    input  logic             clr,
    output logic             F0,
    output logic             F1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // Fill counter must be able to hold the value PAT_W itself.
    localparam int                FILL_W      = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(PAT_W);
    // A window is complete once PAT_W-1 older bits are known plus the bit
    // being sampled now.
    localparam logic [FILL_W-1:0] FILL_THRESH = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    // Channel 0 compares against PAT0, channel 1 against PAT1.
    localparam logic [1:0][PAT_W-1:0] PATS = {PAT1, PAT0};

    logic [PAT_W-1:0]  hist_reg;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;
    logic [PAT_W-1:0]  window;
    logic              window_valid;
    logic              sample;
    logic [1:0]        hit;
    logic              any_hit;
    logic [1:0]        flag_bus;
    logic [1:0][CNT_W-1:0] cnt_bus;

    // clr outranks en, so a clearing edge never samples D.
    assign sample       = en && !clr;
    assign window       = {hist_reg[PAT_W-2:0], D};
    assign window_valid = (fill_reg >= FILL_THRESH);
    assign any_hit      = |hit;

    // Next fill count: restart after a hit in non-overlapped mode, otherwise
    // count up and stick at PAT_W.
    always_comb begin
        fill_next = fill_reg;
        if (!ovl && any_hit) begin
            fill_next = '0;
        end else if (fill_reg != FILL_FULL) begin
            fill_next = fill_reg + 1'b1;
        end
    end

    // History and fill state; both only move on a sampling edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (clr) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (sample) begin
            hist_reg <= window;
            fill_reg <= fill_next;
        end
    end

    // One comparator, flag register and saturating counter per pattern.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             flag_reg;
            logic [CNT_W-1:0] cnt_reg;

            assign hit[gi] = sample && window_valid && (window == PATS[gi]);

            // Flag is a single-cycle pulse; counter sticks at all-ones.
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    flag_reg <= 1'b0;
                    cnt_reg  <= '0;
                end else if (clr) begin
                    flag_reg <= 1'b0;
                    cnt_reg  <= '0;
                end else begin
                    flag_reg <= hit[gi];
                    if (hit[gi] && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign flag_bus[gi] = flag_reg;
            assign cnt_bus[gi]  = cnt_reg;
        end
    endgenerate

    assign F0   = flag_bus[0];
    assign F1   = flag_bus[1];
    assign cnt0 = cnt_bus[0];
    assign cnt1 = cnt_bus[1];

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param.
// Three instances share the stimulus: defaults (a), CNT_W=2 (b) and
// PAT0==PAT1 (c). A behavioural model predicts every output per edge; the
// prediction is queued when the stimulus is driven and compared after the edge.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic d = 1'b0, en = 1'b0, ovl = 1'b0, clr = 1'b0;

    logic       f0_a, f1_a, f0_b, f1_b, f0_c, f1_c;
    logic [7:0] c0_a, c1_a, c0_c, c1_c;
    logic [1:0] c0_b, c1_b;

    seq_detect_param dut_a (
        .clk(clk), .res_n(res_n), .D(d), .en(en), .ovl(ovl), .clr(clr),
        .F0(f0_a), .F1(f1_a), .cnt0(c0_a), .cnt1(c1_a)
    );

    seq_detect_param #(.CNT_W(2)) dut_b (
        .clk(clk), .res_n(res_n), .D(d), .en(en), .ovl(ovl), .clr(clr),
        .F0(f0_b), .F1(f1_b), .cnt0(c0_b), .cnt1(c1_b)
    );

    seq_detect_param #(.PAT0(4'b1101), .PAT1(4'b1101)) dut_c (
        .clk(clk), .res_n(res_n), .D(d), .en(en), .ovl(ovl), .clr(clr),
        .F0(f0_c), .F1(f1_c), .cnt0(c0_c), .cnt1(c1_c)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int txn = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (txn %0d): got %0d, expected %0d", tag, txn, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int p0_tab[3]   = '{13, 13, 13};
    int p1_tab[3]   = '{6, 6, 13};
    int cmax_tab[3] = '{255, 3, 255};

    int m_hist[3], m_fill[3], m_c0[3], m_c1[3];
    bit m_f0[3], m_f1[3];

    typedef struct packed {
        logic [2:0]      f0;
        logic [2:0]      f1;
        logic [2:0][7:0] c0;
        logic [2:0][7:0] c1;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_hist[k] = 0; m_fill[k] = 0; m_c0[k] = 0; m_c1[k] = 0;
            m_f0[k] = 0;   m_f1[k] = 0;
        end
    endtask

    task automatic model_step(input bit d_i, input bit en_i, input bit ovl_i, input bit clr_i);
        for (int k = 0; k < 3; k++) begin
            int w;
            bit ok, h0, h1;
            if (clr_i) begin
                m_hist[k] = 0; m_fill[k] = 0; m_c0[k] = 0; m_c1[k] = 0;
                m_f0[k] = 0;   m_f1[k] = 0;
            end else if (en_i) begin
                w  = ((m_hist[k] << 1) | int'(d_i)) & 15;
                ok = (m_fill[k] >= 3);
                h0 = ok && (w == p0_tab[k]);
                h1 = ok && (w == p1_tab[k]);
                m_hist[k] = w;
                if (!ovl_i && (h0 || h1)) m_fill[k] = 0;
                else if (m_fill[k] < 4)   m_fill[k] = m_fill[k] + 1;
                m_f0[k] = h0;
                m_f1[k] = h1;
                if (h0 && m_c0[k] < cmax_tab[k]) m_c0[k] = m_c0[k] + 1;
                if (h1 && m_c1[k] < cmax_tab[k]) m_c1[k] = m_c1[k] + 1;
            end else begin
                m_f0[k] = 0;
                m_f1[k] = 0;
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            e.f0[k] = m_f0[k];
            e.f1[k] = m_f1[k];
            e.c0[k] = 8'(m_c0[k]);
            e.c1[k] = 8'(m_c1[k]);
        end
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("f0",     {f0_c, f0_b, f0_a}, e.f0);
            chk("f1",     {f1_c, f1_b, f1_a}, e.f1);
            chk("cnt0_a", c0_a, e.c0[0]);
            chk("cnt1_a", c1_a, e.c1[0]);
            chk("cnt0_b", c0_b, e.c0[1]);
            chk("cnt1_b", c1_b, e.c1[1]);
            chk("cnt0_c", c0_c, e.c0[2]);
            chk("cnt1_c", c1_c, e.c1[2]);
        end
    endtask

    // One clock transaction: drive on the falling edge, check 1 ns after rising.
    task automatic cycle(input bit d_i, input bit en_i, input bit ovl_i, input bit clr_i);
        @(negedge clk);
        d = d_i; en = en_i; ovl = ovl_i; clr = clr_i;
        model_step(d_i, en_i, ovl_i, clr_i);
        push_expect();
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d d=%b en=%b ovl=%b clr=%b | F0=%b F1=%b cnt0=%0d cnt1=%0d | b:%0d c:%b%b",
                 txn, d_i, en_i, ovl_i, clr_i, f0_a, f1_a, c0_a, c1_a, c0_b, f0_c, f1_c);
        pop_check();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, {f0_a, f1_a, f0_b, f1_b, f0_c, f1_c}, 32'd0);
        chk({tag, "_cnt_a"}, {c0_a, c1_a}, 32'd0);
        chk({tag, "_cnt_b"}, {c0_b, c1_b}, 32'd0);
        chk({tag, "_cnt_c"}, {c0_c, c1_c}, 32'd0);
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input bit ovl_i);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) cycle(v[i], 1'b1, ovl_i, 1'b0);
    endtask

    initial begin
        model_reset();
        #15;
        check_all_zero("reset");
        @(negedge clk);
        res_n = 1'b1;

        // Overlapped: 1101101 -> F0 after bits 4 and 7, F1 after bit 6.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        feed(16'b1101101, 7, 1'b1);
        chk("ovl_cnt0", c0_a, 32'd2);
        chk("ovl_cnt1", c1_a, 32'd1);

        // Non-overlapped: same stream -> one F0 hit only.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        feed(16'b1101101, 7, 1'b0);
        chk("novl_cnt0", c0_a, 32'd1);
        chk("novl_cnt1", c1_a, 32'd0);

        // Mid-stream async reset: pre-reset bits must not complete 1101.
        feed(16'b110, 3, 1'b0);
        #4;
        res_n = 1'b0;
        model_reset();
        #2;
        check_all_zero("async_rst");
        #8;
        res_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_f0", f0_a, 32'd0);
        chk("rst_cnt0", c0_a, 32'd0);

        // Enable gap: 1,1 / en=0 x3 with D toggling / 0,1 -> F0 on the last bit.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        feed(16'b11, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(i[0], 1'b0, 1'b0, 1'b0);
            chk("gap_f0", f0_a, 32'd0);
        end
        feed(16'b01, 2, 1'b0);
        chk("gap_hit", f0_a, 32'd1);

        // Narrow counter: four overlapped hits saturate the 2-bit count at 3.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        feed(16'b1101101101101, 13, 1'b1);
        chk("sat2_cnt0", c0_b, 32'd3);
        chk("wide_cnt0", c0_a, 32'd4);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_all_zero("clr");

        // Random traffic with occasional ovl changes, enable gaps and clears.
        begin
            bit ovl_r;
            ovl_r = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) ovl_r = ~ovl_r;
                cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), ovl_r,
                      ($urandom_range(0, 59) == 0));
            end
        end

        // Long overlapped run: the 8-bit counter must stop at 255.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) feed(16'b110, 3, 1'b1);
        chk("sat8_cnt0", c0_a, 32'd255);
        chk("sat8_cnt0_c", c1_c, 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so a stalled run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
